// File: rtl/ws2812b_rx_pkg.sv
// Shared WS2812B timing constants (50 MHz) and receiver state type.
// Transmit and receive sides both draw their timing from here.
package ws2812b_rx_pkg;

  localparam int unsigned T0H        = 20;
  localparam int unsigned T1H        = 40;
  localparam int unsigned TBit       = 62;
  localparam int unsigned DefThresh  = 30;
  localparam int unsigned DefMinHigh = 8;
  localparam int unsigned DefMaxHigh = 60;
  localparam int unsigned DefReset   = 2500;
  localparam int unsigned WordBits   = 24;

  typedef enum logic [2:0] {
    StSync,
    StIdle,
    StHigh,
    StLow,
    StPass
  } rx_state_e;

endpackage

// File: rtl/ws2812b_rx_sync_2ff.sv
// Two-flop synchroniser for the asynchronous serial input; both stages reset to 0.
module ws2812b_rx_sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B receiver: decodes the first 24-bit word after a reset gap and forwards
// the remainder of the frame on DOUT, like the first LED of a chain.
module ws2812b_rx
  import ws2812b_rx_pkg::*;
#(
  parameter int unsigned T_THRESH   = DefThresh,
  parameter int unsigned T_MIN_HIGH = DefMinHigh,
  parameter int unsigned T_MAX_HIGH = DefMaxHigh,
  parameter int unsigned T_RESET    = DefReset
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        DIN,
  output logic [23:0] rgb_data,
  output logic        valid,
  output logic        latch,
  output logic        error,
  output logic        DOUT
);

  localparam int unsigned CntW = $clog2(T_RESET + 1);
  localparam logic [CntW-1:0] Thresh   = CntW'(T_THRESH);
  localparam logic [CntW-1:0] MinHigh  = CntW'(T_MIN_HIGH);
  localparam logic [CntW-1:0] MaxHigh  = CntW'(T_MAX_HIGH);
  localparam logic [CntW-1:0] ResetLen = CntW'(T_RESET);
  localparam logic [CntW-1:0] One      = CntW'(1);
  localparam logic [4:0]      LastBit  = 5'(WordBits - 1);

  logic din_s;
  logic din_d_q;

  rx_state_e       state_q, state_d;
  logic [CntW-1:0] hcnt_q, hcnt_d;
  logic [CntW-1:0] lcnt_q, lcnt_d;
  logic [22:0]     shreg_q, shreg_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic [23:0]     rgb_q, rgb_d;
  logic            valid_q, valid_d;
  logic            latch_q, latch_d;
  logic            error_q, error_d;
  logic            dout_q, dout_d;

  logic [CntW-1:0] hcnt_inc, lcnt_inc;
  logic [23:0]     word_next;

  ws2812b_rx_sync_2ff u_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .d_i   (DIN),
    .q_o   (din_s)
  );

  always_comb begin
    hcnt_inc  = (hcnt_q == MaxHigh) ? hcnt_q : hcnt_q + One;
    lcnt_inc  = (lcnt_q == ResetLen) ? lcnt_q : lcnt_q + One;
    word_next = {shreg_q, (hcnt_q >= Thresh)};

    state_d   = state_q;
    hcnt_d    = hcnt_q;
    lcnt_d    = lcnt_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    rgb_d     = rgb_q;
    valid_d   = 1'b0;
    latch_d   = 1'b0;
    error_d   = 1'b0;
    dout_d    = 1'b0;

    unique case (state_q)
      StSync: begin
        if (din_s) begin
          lcnt_d = '0;
        end else begin
          lcnt_d = lcnt_inc;
          if (lcnt_inc == ResetLen) state_d = StIdle;
        end
      end
      StIdle: begin
        if (din_s && !din_d_q) begin
          hcnt_d  = One;
          state_d = StHigh;
        end
      end
      StHigh: begin
        if (din_s) begin
          hcnt_d = hcnt_inc;
          if (hcnt_inc == MaxHigh) begin
            error_d   = 1'b1;
            bit_cnt_d = '0;
            lcnt_d    = '0;
            state_d   = StSync;
          end
        end else if (hcnt_q < MinHigh) begin
          // The falling sample is already low, so it counts towards the resync gap.
          error_d   = 1'b1;
          bit_cnt_d = '0;
          lcnt_d    = One;
          state_d   = StSync;
        end else begin
          shreg_d   = word_next[22:0];
          bit_cnt_d = bit_cnt_q + 5'd1;
          lcnt_d    = One;
          if (bit_cnt_q == LastBit) begin
            rgb_d   = word_next;
            valid_d = 1'b1;
            state_d = StPass;
          end else begin
            state_d = StLow;
          end
        end
      end
      StLow: begin
        if (din_s) begin
          hcnt_d  = One;
          state_d = StHigh;
        end else begin
          lcnt_d = lcnt_inc;
          if (lcnt_inc == ResetLen) begin
            error_d   = (bit_cnt_q != '0);
            latch_d   = 1'b1;
            bit_cnt_d = '0;
            state_d   = StIdle;
          end
        end
      end
      StPass: begin
        dout_d = din_s;
        if (din_s) begin
          lcnt_d = '0;
        end else begin
          lcnt_d = lcnt_inc;
          if (lcnt_inc == ResetLen) begin
            dout_d    = 1'b0;
            latch_d   = 1'b1;
            bit_cnt_d = '0;
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StSync;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StSync;
      din_d_q   <= 1'b0;
      hcnt_q    <= '0;
      lcnt_q    <= '0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      rgb_q     <= '0;
      valid_q   <= 1'b0;
      latch_q   <= 1'b0;
      error_q   <= 1'b0;
      dout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      din_d_q   <= din_s;
      hcnt_q    <= hcnt_d;
      lcnt_q    <= lcnt_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      rgb_q     <= rgb_d;
      valid_q   <= valid_d;
      latch_q   <= latch_d;
      error_q   <= error_d;
      dout_q    <= dout_d;
    end
  end

  assign rgb_data = rgb_q;
  assign valid    = valid_q;
  assign latch    = latch_q;
  assign error    = error_q;
  assign DOUT     = dout_q;

endmodule

// File: tb/tb_ws2812b_rx.sv
// Bench for ws2812b_rx: builds a DIN waveform, derives expected outputs from its
// run lengths, and compares the DUT against that expectation every cycle.
module tb_ws2812b_rx;
  import ws2812b_rx_pkg::*;

  localparam int TR   = DefReset;
  localparam int TTh  = DefThresh;
  localparam int TMin = DefMinHigh;
  localparam int TMax = DefMaxHigh;
  localparam int Gap  = DefReset + 20;
  localparam int Lat  = 3;

  localparam int MUnsync = 0;
  localparam int MIdle   = 1;
  localparam int MDecode = 2;
  localparam int MFwd    = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        DIN = 1'b0;
  logic [23:0] rgb_data;
  logic        valid, latch, error, DOUT;

  int tests = 0;
  int fails = 0;

  bit          wave[$];
  bit          e_valid[$], e_latch[$], e_err[$], e_dout[$];
  logic [23:0] e_word[$];
  logic [23:0] m_words[$];
  logic [23:0] dut_words[$];
  int          n_val, n_lat, n_err, n_errlat;

  ws2812b_rx dut (
    .CLK      (CLK),
    .RST      (RST),
    .DIN      (DIN),
    .rgb_data (rgb_data),
    .valid    (valid),
    .latch    (latch),
    .error    (error),
    .DOUT     (DOUT)
  );

  always #5 CLK = ~CLK;

  task automatic level(input bit v, input int n);
    repeat (n) wave.push_back(v);
  endtask

  task automatic bitp(input int hi, input int lo);
    level(1'b1, hi);
    level(1'b0, lo);
  endtask

  task automatic word_nom(input logic [23:0] w, input int nb);
    for (int k = 23; k > 23 - nb; k--) begin
      if (w[k]) bitp(T1H, TBit - T1H);
      else      bitp(T0H, TBit - T0H);
    end
  endtask

  task automatic word_rand(input logic [23:0] w);
    int hi, lo;
    for (int k = 23; k >= 0; k--) begin
      hi = w[k] ? int'($urandom_range(TMax - 1, TTh)) : int'($urandom_range(TTh - 1, TMin));
      lo = int'($urandom_range(60, 1));
      bitp(hi, lo);
    end
  endtask

  // Walk the waveform run by run; high-run length decides the bit, low-run length the gap.
  task automatic build_model(input bit synced);
    int n, s, len, f, nb, mode;
    bit v;
    logic [23:0] acc;
    n = wave.size();
    s = 0;
    nb = 0;
    acc = '0;
    mode = synced ? MIdle : MUnsync;
    e_valid.delete(); e_latch.delete(); e_err.delete(); e_dout.delete();
    e_word.delete(); m_words.delete();
    for (int i = 0; i < n; i++) begin
      e_valid.push_back(1'b0); e_latch.push_back(1'b0); e_err.push_back(1'b0);
      e_dout.push_back(1'b0); e_word.push_back('0);
    end
    while (s < n) begin
      v = wave[s];
      len = 0;
      while (s + len < n && wave[s + len] == v) len++;
      if (mode == MFwd) begin
        if (v) begin
          for (int i = 0; i < len; i++) e_dout[s + i] = 1'b1;
        end else if (len >= TR) begin
          e_latch[s + TR - 1] = 1'b1;
          mode = MIdle;
        end
      end else if (mode == MUnsync) begin
        if (!v && len >= TR) mode = MIdle;
      end else if (v) begin
        if (len >= TMax) begin
          e_err[s + TMax - 1] = 1'b1;
          mode = MUnsync;
          nb = 0;
        end else if (s + len < n) begin
          f = s + len;
          if (len < TMin) begin
            e_err[f] = 1'b1;
            mode = MUnsync;
            nb = 0;
          end else begin
            acc = {acc[22:0], (len >= TTh)};
            nb++;
            if (nb == 24) begin
              e_valid[f] = 1'b1;
              e_word[f] = acc;
              m_words.push_back(acc);
              nb = 0;
              mode = MFwd;
            end else begin
              mode = MDecode;
            end
          end
        end
      end else if (mode == MDecode && len >= TR) begin
        e_err[s + TR - 1] = 1'b1;
        e_latch[s + TR - 1] = 1'b1;
        nb = 0;
        mode = MIdle;
      end
      s += len;
    end
    n_val = 0; n_lat = 0; n_err = 0; n_errlat = 0;
    for (int i = 0; i < n; i++) begin
      n_val += int'(e_valid[i]);
      n_lat += int'(e_latch[i]);
      n_err += int'(e_err[i]);
      n_errlat += int'(e_err[i] & e_latch[i]);
    end
  endtask

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // Output at negedge i reflects the DIN sample driven Lat negedges earlier.
  task automatic play(input int upto, input logic [23:0] rgb0, output logic [23:0] rgb_last);
    logic [23:0] er;
    bit ev, el, ee, ed;
    int j;
    er = rgb0;
    for (int i = 0; i < upto; i++) begin
      @(negedge CLK);
      j = i - Lat;
      ev = 1'b0; el = 1'b0; ee = 1'b0; ed = 1'b0;
      if (j >= 0 && j < wave.size()) begin
        ev = e_valid[j]; el = e_latch[j]; ee = e_err[j]; ed = e_dout[j];
        if (ev) er = e_word[j];
      end
      tests++;
      if (valid !== ev || latch !== el || error !== ee || DOUT !== ed || rgb_data !== er) begin
        fails++;
        if (fails <= 20)
          $display("FAIL cycle %0d: got v/l/e/dout=%b%b%b%b rgb=%h, required %b%b%b%b rgb=%h",
                   j, valid, latch, error, DOUT, rgb_data, ev, el, ee, ed, er);
      end
      if (valid === 1'b1) dut_words.push_back(rgb_data);
      DIN = (i < wave.size()) ? wave[i] : 1'b0;
    end
    rgb_last = er;
  endtask

  logic [23:0] lit1 [4];
  logic [23:0] rgb_now, rgb_tmp, rw0, rw1, w;
  int          hi, k_abort;

  initial begin
    lit1 = '{24'hFF0000, 24'h00FF00, 24'h35A5A5, 24'hA5A5A5};

    repeat (3) @(negedge CLK);
    pin("reset rgb_data", 32'(rgb_data), 32'h0);
    pin("reset valid", 32'(valid), 32'h0);
    pin("reset latch", 32'(latch), 32'h0);
    pin("reset error", 32'(error), 32'h0);
    pin("reset DOUT", 32'(DOUT), 32'h0);
    RST = 1'b0;

    // Phase 1: directed frames, boundary pulse widths, error cases, random words.
    level(1'b0, Gap);
    word_nom(24'hFF0000, 24); level(1'b0, Gap);
    word_nom(24'h00FF00, 24); word_nom(24'h0000FF, 24); level(1'b0, Gap);
    w = 24'h35A5A5;
    for (int k = 23; k >= 0; k--) begin
      case (k)
        23: hi = TMin;
        22: hi = TTh - 1;
        21: hi = TTh;
        20: hi = TMax - 1;
        default: hi = w[k] ? T1H : T0H;
      endcase
      bitp(hi, (k == 11) ? TR - 1 : 30);
    end
    level(1'b0, Gap);
    word_nom(24'hAAAAAA, 10); bitp(5, 40); word_nom(24'h0F0F0F, 24); level(1'b0, Gap);
    w = 24'hABCDEF;
    for (int k = 23; k >= 12; k--) begin
      hi = w[k] ? T1H : T0H;
      bitp(hi, (k == 12) ? TR : TBit - hi);
    end
    word_nom(24'hA5A5A5, 24); level(1'b0, Gap);
    level(1'b1, 100); level(1'b0, Gap);
    level(1'b1, TMax); level(1'b0, Gap);
    word_nom(24'hFFFFFF, 3); bitp(TMin - 1, 40); level(1'b0, Gap);
    for (int r = 0; r < 3; r++) begin
      rw0 = 24'($urandom);
      word_rand(rw0); level(1'b0, Gap);
    end
    rw0 = 24'($urandom); rw1 = 24'($urandom);
    word_rand(rw0); word_rand(rw1); level(1'b0, Gap);

    build_model(1'b0);
    pin("model valid count", 32'(n_val), 32'd8);
    pin("model latch count", 32'(n_lat), 32'd9);
    pin("model error count", 32'(n_err), 32'd5);
    pin("model error+latch count", 32'(n_errlat), 32'd1);
    for (int k = 0; k < 4; k++)
      pin($sformatf("model word%0d", k), (k < m_words.size()) ? 32'(m_words[k]) : 32'hDEAD,
          32'(lit1[k]));

    dut_words.delete();
    play(wave.size() + Lat, 24'h0, rgb_now);
    pin("dut valid count", 32'(dut_words.size()), 32'd8);
    for (int k = 0; k < 4; k++)
      pin($sformatf("dut word%0d", k), (k < dut_words.size()) ? 32'(dut_words[k]) : 32'hDEAD,
          32'(lit1[k]));

    // Phase 2: abort a word with RST partway into bit 11.
    wave.delete();
    level(1'b0, 100);
    word_nom(24'h777777, 24);
    k_abort = 100 + 10 * TBit + 10;
    build_model(1'b1);
    play(k_abort, rgb_now, rgb_tmp);
    #2 RST = 1'b1;
    #1;
    pin("abort rgb_data", 32'(rgb_data), 32'h0);
    pin("abort valid", 32'(valid), 32'h0);
    pin("abort latch", 32'(latch), 32'h0);
    pin("abort error", 32'(error), 32'h0);
    pin("abort DOUT", 32'(DOUT), 32'h0);
    DIN = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;

    // Phase 3: a word before the gap must be ignored; the one after decodes.
    wave.delete();
    level(1'b0, 100);
    word_nom(24'h654321, 24); level(1'b0, Gap);
    word_nom(24'h123456, 24); level(1'b0, Gap);
    build_model(1'b0);
    pin("model resync valid count", 32'(n_val), 32'd1);
    pin("model resync word", (m_words.size() > 0) ? 32'(m_words[0]) : 32'hDEAD, 32'h123456);
    dut_words.delete();
    play(wave.size() + Lat, 24'h0, rgb_tmp);
    pin("dut resync valid count", 32'(dut_words.size()), 32'd1);
    pin("dut resync word", (dut_words.size() > 0) ? 32'(dut_words[0]) : 32'hDEAD, 32'h123456);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
